// File: rtl/synth_reg_write_arbiter.sv
// synth_reg_write_arbiter
//   Round-robin arbiter that lets several host receivers (SPI, UART, I2C) share
//   the synthesizer control-register bank. One single-byte write is granted per
//   clock. Frequency bytes are staged in shadow registers and committed together,
//   so the oscillator never sees a partially updated frequency.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/addr/data per-requester write request; byte lane i at [8i+7:8i]
//   req_ready           one-hot grant (combinational)
//   reg_control..volume register bank outputs
//   reg_status          {5'b0, collision_sticky, osc_running, gate_active}
//   freq_commit         one-cycle pulse alongside a committed frequency update
//   status_*            live status inputs folded into reg_status
module synth_reg_write_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             reg_control,
    output logic [7:0]             reg_freq_low,
    output logic [7:0]             reg_freq_mid,
    output logic [7:0]             reg_freq_high,
    output logic [7:0]             reg_duty,
    output logic [7:0]             reg_volume,
    output logic [7:0]             reg_status,
    output logic                   freq_commit,
    input  logic                   status_gate_active,
    input  logic                   status_osc_running
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_next;
    logic [7:0]       shadow_low;
    logic [7:0]       shadow_mid;
    logic             collision_sticky;

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [7:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             collision;
    int               valid_cnt;

    // Grant the first valid requester at or after rr_ptr (modulo NUM_REQ).
    // Offset k is the outer loop so lower offsets win.
    always_comb begin
        req_ready = '0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!wr_en && req_valid[i] && ((int'(rr_ptr) + k) % NUM_REQ == i)) begin
                    wr_en        = 1'b1;
                    req_ready[i] = 1'b1;
                    wr_idx       = PTR_W'(i);
                    wr_addr      = req_addr[8*i +: 8];
                    wr_data      = req_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (wr_en) begin
            rr_ptr_next = (int'(wr_idx) == NUM_REQ - 1) ? '0 : PTR_W'(int'(wr_idx) + 1);
        end
    end

    always_comb begin
        valid_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_cnt = valid_cnt + int'(req_valid[i]);
        end
        collision = (valid_cnt >= 2);
    end

    assign reg_status = {5'b0, collision_sticky, status_osc_running, status_gate_active};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr           <= '0;
            shadow_low       <= 8'h00;
            shadow_mid       <= 8'h00;
            collision_sticky <= 1'b0;
            reg_control      <= 8'h1C;
            reg_freq_low     <= 8'h00;
            reg_freq_mid     <= 8'h00;
            reg_freq_high    <= 8'h00;
            reg_duty         <= 8'h80;
            reg_volume       <= 8'hFF;
            freq_commit      <= 1'b0;
        end else begin
            freq_commit <= 1'b0;
            rr_ptr      <= rr_ptr_next;
            if (collision) begin
                collision_sticky <= 1'b1;
            end
            if (wr_en) begin
                case (wr_addr)
                    8'h00: reg_control <= wr_data;
                    8'h02: shadow_low  <= wr_data;
                    8'h03: shadow_mid  <= wr_data;
                    8'h04: begin
                        // All three bytes land together; shadows are kept so a
                        // lone high-byte write re-commits the previous low/mid.
                        reg_freq_low  <= shadow_low;
                        reg_freq_mid  <= shadow_mid;
                        reg_freq_high <= wr_data;
                        freq_commit   <= 1'b1;
                    end
                    8'h05: reg_duty    <= wr_data;
                    8'h06: reg_volume  <= wr_data;
                    // Status (0x12) and unmapped addresses are accepted and dropped.
                    default: ;
                endcase
            end
        end
    end

endmodule
